// File: rtl/tetris_pkg.sv
// ============================================================================
// Module  : tetris_pkg
// Brief   : Shared frame constants and streamer FSM encoding.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

package tetris_pkg;

  localparam logic [7:0] FRAME_HDR0 = 8'hA5;
  localparam logic [7:0] FRAME_HDR1 = 8'h5A;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_HDR0  = 3'd1;
  localparam logic [2:0] ST_HDR1  = 3'd2;
  localparam logic [2:0] ST_FETCH = 3'd3;
  localparam logic [2:0] ST_LATCH = 3'd4;
  localparam logic [2:0] ST_SEND  = 3'd5;
  localparam logic [2:0] ST_CSUM  = 3'd6;
  localparam logic [2:0] ST_DONE  = 3'd7;

  // Two bits per cell, eight bits per serial byte.
  function automatic int bytes_per_row(input int area_col);
    return area_col * 2 / 8;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_byte_tx.sv
// ============================================================================
// Module  : uart_byte_tx
// Brief   : 8N1 byte serialiser with a back-to-back load handshake.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module uart_byte_tx #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115_200
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [7:0] data,
  input  logic       load,
  output logic       tx_ready,
  output logic       tx
);

  localparam int DIV   = CLK_FREQ / BAUD;
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic             r_busy;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_bit;
  logic [9:0]       r_shift;
  logic             w_bit_end;

  assign w_bit_end = (r_cnt == CNT_W'(DIV - 1));
  // Ready during the final stop-bit cycle lets the next start bit follow with no gap.
  assign tx_ready  = !r_busy || (w_bit_end && (r_bit == 4'd9));
  assign tx        = r_shift[0];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_busy  <= 1'b0;
      r_cnt   <= '0;
      r_bit   <= 4'd0;
      r_shift <= '1;
    end else if (load && tx_ready) begin
      r_busy  <= 1'b1;
      r_cnt   <= '0;
      r_bit   <= 4'd0;
      r_shift <= {1'b1, data, 1'b0};
    end else if (r_busy) begin
      if (w_bit_end) begin
        r_cnt   <= '0;
        r_shift <= {1'b1, r_shift[9:1]};
        if (r_bit == 4'd9) begin
          r_busy <= 1'b0;
        end else begin
          r_bit <= r_bit + 1'b1;
        end
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/bitmap_uart_streamer.sv
// ============================================================================
// Module  : bitmap_uart_streamer
// Brief   : Periodically snapshots the playfield and streams a checksummed frame over UART.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module bitmap_uart_streamer
  import tetris_pkg::*;
#(
  parameter int CLK_FREQ     = 50_000_000,
  parameter int BAUD         = 115_200,
  parameter int AREA_ROW     = 32,
  parameter int AREA_COL     = 16,
  parameter int ROW_ADDR_W   = 5,
  parameter int FRAME_PERIOD = 5_000_000
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  enable,
  output logic [ROW_ADDR_W-1:0] bitmap_row,
  input  logic [AREA_COL*2-1:0] bitmap_data,
  output logic                  uart_tx,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int ROW_W         = AREA_COL * 2;
  localparam int BYTES_PER_ROW = bytes_per_row(AREA_COL);
  localparam int IDX_W         = $clog2(BYTES_PER_ROW + 1);
  localparam int PER_W         = (FRAME_PERIOD > 1) ? $clog2(FRAME_PERIOD) : 1;

  logic [2:0]            r_state;
  logic [PER_W-1:0]      r_period;
  logic                  r_pending;
  logic [ROW_ADDR_W-1:0] r_row;
  logic [IDX_W-1:0]      r_idx;
  logic [ROW_W-1:0]      r_row_buf;
  logic [7:0]            r_csum;

  logic                  w_tick;
  logic                  w_start;
  logic                  w_last_row;
  logic                  w_row_sent;
  logic                  w_tx_ready;
  logic                  w_load;
  logic                  w_payload;
  logic [7:0]            w_byte;

  assign w_tick     = (r_period == PER_W'(FRAME_PERIOD - 1));
  assign w_start    = (r_state == ST_IDLE) && ((w_tick && enable) || r_pending);
  assign w_last_row = (r_row == ROW_ADDR_W'(AREA_ROW - 1));
  assign w_row_sent = (r_idx == IDX_W'(BYTES_PER_ROW));

  assign bitmap_row = r_row;
  assign busy       = (r_state != ST_IDLE) && (r_state != ST_DONE);
  assign frame_done = (r_state == ST_DONE);

  // LATCH loads the first row byte straight from bitmap_data so only FETCH/LATCH idle the line.
  always_comb begin
    w_load    = 1'b0;
    w_payload = 1'b0;
    w_byte    = 8'h00;
    case (r_state)
      ST_HDR0: begin
        w_load = w_tx_ready;
        w_byte = FRAME_HDR0;
      end
      ST_HDR1: begin
        w_load = w_tx_ready;
        w_byte = FRAME_HDR1;
      end
      ST_LATCH: begin
        w_load    = w_tx_ready;
        w_payload = w_tx_ready;
        w_byte    = bitmap_data[ROW_W-1 -: 8];
      end
      ST_SEND: begin
        w_load    = w_tx_ready && !w_row_sent;
        w_payload = w_tx_ready && !w_row_sent;
        w_byte    = r_row_buf[ROW_W-1 -: 8];
      end
      ST_CSUM: begin
        w_load = w_tx_ready && (r_idx == '0);
        w_byte = r_csum;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= ST_IDLE;
      r_period  <= '0;
      r_pending <= 1'b0;
      r_row     <= '0;
      r_idx     <= '0;
      r_row_buf <= '0;
      r_csum    <= 8'h00;
    end else begin
      r_period <= w_tick ? '0 : r_period + 1'b1;

      if (r_state == ST_IDLE) begin
        r_pending <= 1'b0;
      end else if (w_tick && enable) begin
        r_pending <= 1'b1;
      end

      if (w_payload) begin
        r_csum <= r_csum ^ w_byte;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_state <= ST_HDR0;
            r_csum  <= 8'h00;
            r_row   <= '0;
          end
        end
        ST_HDR0:  if (w_tx_ready) r_state <= ST_HDR1;
        ST_HDR1:  if (w_tx_ready) r_state <= ST_FETCH;
        ST_FETCH: r_state <= ST_LATCH;
        ST_LATCH: begin
          r_row_buf <= w_tx_ready ? (bitmap_data << 8) : bitmap_data;
          r_idx     <= w_tx_ready ? IDX_W'(1) : '0;
          r_state   <= ST_SEND;
        end
        ST_SEND: begin
          if (w_row_sent) begin
            if (w_last_row) begin
              r_idx   <= '0;
              r_state <= ST_CSUM;
            end else if (w_tx_ready) begin
              r_row   <= r_row + 1'b1;
              r_state <= ST_FETCH;
            end
          end else if (w_tx_ready) begin
            r_row_buf <= r_row_buf << 8;
            r_idx     <= r_idx + 1'b1;
          end
        end
        ST_CSUM: begin
          if (w_tx_ready) begin
            if (r_idx == '0) begin
              r_idx <= IDX_W'(1);
            end else begin
              r_state <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          r_row   <= '0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  uart_byte_tx #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD)
  ) u_tx (
    .clk      (clk),
    .rstn     (rstn),
    .data     (w_byte),
    .load     (w_load),
    .tx_ready (w_tx_ready),
    .tx       (uart_tx)
  );

endmodule

`default_nettype wire

// File: tb/tb_bitmap_uart_streamer.sv
// ============================================================================
// Module  : tb_bitmap_uart_streamer
// Brief   : Scoreboard bench: frame model feeds a queue, a UART decoder pops and compares.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_bitmap_uart_streamer;

  localparam int DIV      = 10;
  localparam int AREA_ROW = 4;
  localparam int ROW_W    = 32;

  logic        clk = 1'b0;
  logic        rstn;
  logic        enable;
  logic [4:0]  bitmap_row;
  logic [31:0] bitmap_data = 32'h0;
  logic        uart_tx;
  logic        busy;
  logic        frame_done;

  logic        rstn2;
  logic        enable2;
  logic [4:0]  bitmap_row2;
  logic        uart_tx2;
  logic        busy2;
  logic        frame_done2;

  logic [31:0] mem [0:31];
  logic [7:0]  exp_q [$];
  int          checks   = 0;
  int          failures = 0;
  int          rx_count = 0;

  always #5 clk = ~clk;

  bitmap_uart_streamer #(
    .CLK_FREQ(1000), .BAUD(100), .AREA_ROW(AREA_ROW), .AREA_COL(16),
    .ROW_ADDR_W(5), .FRAME_PERIOD(2000)
  ) dut (
    .clk(clk), .rstn(rstn), .enable(enable), .bitmap_row(bitmap_row),
    .bitmap_data(bitmap_data), .uart_tx(uart_tx), .busy(busy), .frame_done(frame_done)
  );

  // Short period so several ticks land inside one frame.
  bitmap_uart_streamer #(
    .CLK_FREQ(1000), .BAUD(100), .AREA_ROW(AREA_ROW), .AREA_COL(16),
    .ROW_ADDR_W(5), .FRAME_PERIOD(500)
  ) dut_p (
    .clk(clk), .rstn(rstn2), .enable(enable2), .bitmap_row(bitmap_row2),
    .bitmap_data(32'h0), .uart_tx(uart_tx2), .busy(busy2), .frame_done(frame_done2)
  );

  // Game-core read port: data follows the row address by one cycle.
  always @(posedge clk) bitmap_data <= mem[bitmap_row];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic push_frame();
    logic [7:0] cs;
    cs = 8'h00;
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h5A);
    for (int r = 0; r < AREA_ROW; r++) begin
      for (int b = ROW_W / 8 - 1; b >= 0; b--) begin
        logic [7:0] v;
        v = mem[r][b*8 +: 8];
        exp_q.push_back(v);
        cs = cs ^ v;
      end
    end
    exp_q.push_back(cs);
  endtask

  task automatic randomize_rows();
    for (int r = 0; r < AREA_ROW; r++) mem[r] = $urandom;
  endtask

  task automatic wait_done(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (frame_done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_done2(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (frame_done2) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_rx(input int target, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (rx_count >= target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic post_frame_checks(input string tag);
    @(negedge clk);
    check({tag, "_done_single"}, {31'd0, frame_done}, 32'd0);
    check({tag, "_busy_low"}, {31'd0, busy}, 32'd0);
    check({tag, "_row_zero"}, {27'd0, bitmap_row}, 32'd0);
    check({tag, "_all_bytes_seen"}, exp_q.size(), 32'd0);
  endtask

  // UART decoder: samples every cycle so each bit must hold for exactly DIV cycles.
  initial begin
    logic [99:0] smp;
    logic [7:0]  d;
    int          n;
    bit          active;
    bit          ok;
    active = 1'b0;
    n = 0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        active = 1'b0;
      end else if (!active) begin
        if (uart_tx === 1'b0) begin
          active = 1'b1;
          smp[0] = 1'b0;
          n = 1;
        end
      end else begin
        smp[n] = uart_tx;
        n++;
        if (n == 10 * DIV) begin
          active = 1'b0;
          ok = 1'b1;
          for (int b = 0; b < 10; b++)
            for (int k = 1; k < DIV; k++)
              if (smp[b*DIV + k] !== smp[b*DIV]) ok = 1'b0;
          for (int i = 0; i < 8; i++) d[i] = smp[(i + 1) * DIV + DIV / 2];
          check($sformatf("rx%0d_bit_timing", rx_count), {31'd0, ok}, 32'd1);
          check($sformatf("rx%0d_stop_bit", rx_count), {31'd0, smp[9*DIV + DIV/2]}, 32'd1);
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL rx%0d_unexpected_byte actual=%h required=none", rx_count, d);
          end else begin
            check($sformatf("rx%0d_byte", rx_count), {24'd0, d}, {24'd0, exp_q.pop_front()});
          end
          rx_count++;
        end
      end
    end
  end

  // frame_done must be a lone pulse with busy already low.
  initial begin
    logic fd_prev, fd2_prev;
    fd_prev = 1'b0;
    fd2_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (frame_done) check("done_pulse_shape", {30'd0, busy, fd_prev}, 32'd0);
      if (frame_done2) check("done2_pulse_shape", {30'd0, busy2, fd2_prev}, 32'd0);
      fd_prev = frame_done;
      fd2_prev = frame_done2;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int first_low;
    int base;
    int gap;
    bit seen_busy, seen_low, seen_row;
    logic [31:0] old_row1;

    rstn = 1'b0;
    rstn2 = 1'b0;
    enable = 1'b1;
    enable2 = 1'b1;
    for (int r = 0; r < 32; r++) mem[r] = 32'h0;
    repeat (5) @(negedge clk);
    check("reset_uart_tx", {31'd0, uart_tx}, 32'd1);
    check("reset_row", {27'd0, bitmap_row}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, frame_done}, 32'd0);
    check("reset2_uart_tx", {31'd0, uart_tx2}, 32'd1);

    // Frame 1: single set row exposes byte order and checksum.
    mem[2] = 32'h8000_0001;
    push_frame();
    rstn = 1'b1;
    first_low = 0;
    for (int i = 1; i <= 2100; i++) begin
      @(negedge clk);
      if (uart_tx === 1'b0) begin
        first_low = i;
        break;
      end
    end
    check("first_start_bit_window", {31'd0, (first_low > 1999) && (first_low <= 2005)}, 32'd1);
    wait_done(2500, ok);
    check("frame1_done_seen", {31'd0, ok}, 32'd1);
    post_frame_checks("frame1");

    // Frame 2: row 1 changes while it is being sent; the latched copy must go out.
    randomize_rows();
    old_row1 = mem[1];
    push_frame();
    base = rx_count;
    wait_rx(base + 7, 5000, ok);
    check("frame2_row1_reached", {31'd0, ok}, 32'd1);
    mem[1] = ~old_row1;
    wait_done(3000, ok);
    check("frame2_done_seen", {31'd0, ok}, 32'd1);
    post_frame_checks("frame2");

    // Frame 3: reset inside row 1 byte 2, then a clean frame afterwards.
    randomize_rows();
    push_frame();
    base = rx_count;
    wait_rx(base + 8, 5000, ok);
    check("frame3_row1_reached", {31'd0, ok}, 32'd1);
    repeat (30) @(negedge clk);
    rstn = 1'b0;
    #1;
    check("midreset_uart_tx", {31'd0, uart_tx}, 32'd1);
    check("midreset_busy", {31'd0, busy}, 32'd0);
    check("midreset_row", {27'd0, bitmap_row}, 32'd0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    randomize_rows();
    push_frame();
    rstn = 1'b1;
    wait_done(4500, ok);
    check("frame4_done_seen", {31'd0, ok}, 32'd1);
    enable = 1'b0;
    post_frame_checks("frame4");

    // Pending: ticks during frame A queue exactly one follow-on frame.
    rstn2 = 1'b1;
    wait_done2(3000, ok);
    check("pend_frameA_done", {31'd0, ok}, 32'd1);
    enable2 = 1'b0;
    gap = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (busy2) begin
        gap = i;
        break;
      end
    end
    check("pend_restart_gap_ok", {31'd0, (gap >= 1) && (gap <= 2)}, 32'd1);
    wait_done2(3000, ok);
    check("pend_frameB_done", {31'd0, ok}, 32'd1);
    seen_busy = 1'b0;
    seen_low = 1'b0;
    seen_row = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      if (busy2 || busy) seen_busy = 1'b1;
      if (uart_tx2 !== 1'b1 || uart_tx !== 1'b1) seen_low = 1'b1;
      if (bitmap_row2 != 5'd0) seen_row = 1'b1;
    end
    check("no_frame_when_disabled", {31'd0, seen_busy}, 32'd0);
    check("line_idle_when_disabled", {31'd0, seen_low}, 32'd0);
    check("pend_row_parked", {31'd0, seen_row}, 32'd0);
    check("no_leftover_expected", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/bitmap_uart_streamer.md
Name: bitmap_uart_streamer

Overview:
- Downstream consumer of the game core's second bitmap read channel.
- Periodically walks every playfield row, snapshots each row, and serialises one framed, checksummed image over a UART 8N1 line so the PC viewer can mirror the board.
- Sits between the game wrapper's r2 row/data port and the board's uart_tx pin, in the clk (system) domain.

Parameters:
- CLK_FREQ, 50_000_000, system clock in Hz.
- BAUD, 115_200, UART bit rate. Bit period DIV = CLK_FREQ/BAUD, truncated (434 at defaults).
- AREA_ROW, 32, playfield rows.
- AREA_COL, 16, playfield columns. Each row is AREA_COL*2 bits; AREA_COL must be a multiple of 4.
- ROW_ADDR_W, 5, row address width.
- FRAME_PERIOD, 5_000_000, cycles between frame triggers (10 frames/s at defaults).

Ports:
- clk, input, 1, system clock.
- rstn, input, 1, asynchronous active-low reset.
- enable, input, 1, frame triggers are honoured only while high.
- bitmap_row, output, ROW_ADDR_W, row address to the game core.
- bitmap_data, input, AREA_COL*2, row contents, valid 1 cycle after bitmap_row changes.
- uart_tx, output, 1, serial line, idle high.
- busy, output, 1, high from frame start through the last checksum stop bit.
- frame_done, output, 1, single-cycle pulse after the final stop bit.

Behaviour:
- Reset (rstn low, asynchronous): uart_tx=1, bitmap_row=0, busy=0, frame_done=0.
  - All counters, the pending flag, the checksum and the FSM return to IDLE.
  - Reset mid-byte aborts immediately; no partial frame is resumed.
- Period counter: free-running 0..FRAME_PERIOD-1; the wrap cycle is a "tick".
  - Tick with enable=1 and FSM in IDLE: frame starts next cycle.
  - Tick with enable=1 while busy: sets pending (single-deep; further ticks are dropped). Pending starts a frame the cycle after returning to IDLE, then clears.
  - enable=0 on a tick: ignored. Deasserting enable mid-frame does not abort the frame.
- Frame byte order:
  - 0xA5, 0x5A.
  - AREA_ROW rows × (AREA_COL*2/8) bytes, row 0 first, each row MSB byte first.
  - One checksum byte = XOR of all payload bytes. The header is excluded from the checksum.
  - Defaults: 2 + 128 + 1 = 131 bytes.
- FSM states: IDLE -> HDR0 -> HDR1 -> FETCH -> LATCH -> SEND -> (FETCH | CSUM) -> DONE -> IDLE.
  - FETCH: drive bitmap_row = row counter.
  - LATCH: 1 cycle later, capture bitmap_data into a row shift register. Bytes are sent from this copy, so later changes in bitmap_data do not tear the row.
  - SEND: emit the row's bytes in sequence, updating the checksum as each byte is loaded.
    - After the last byte, if row == AREA_ROW-1: go to CSUM.
    - Otherwise: row+1 and go to FETCH.
  - Row counter does not wrap mid-frame. bitmap_row returns to 0 in DONE.
  - DONE: frame_done=1 for exactly 1 cycle, busy drops in the same cycle.
- Byte transmitter:
  - Start bit 0, 8 data bits LSB first, stop bit 1; each bit held exactly DIV cycles.
  - The next byte's start bit immediately follows the previous stop bit (no idle gap inside a frame), except across FETCH/LATCH, which add 2 idle-high cycles per row.
  - Handshake: load accepted only when tx_ready=1. tx_ready drops the cycle after load and rises on the last stop-bit cycle.
- Arithmetic:
  - Baud counter width is clog2(DIV).
  - Checksum is 8-bit XOR, cleared when the frame starts.

Decomposition:
- Shared package tetris_pkg (constants only):
  - FRAME_HDR0=8'hA5, FRAME_HDR1=8'h5A.
  - Streamer FSM state encoding.
  - BYTES_PER_ROW = AREA_COL*2/8.
- Sub-module uart_byte_tx (params CLK_FREQ, BAUD; ports clk, rstn, data[7:0], load, tx_ready, tx).
  - Owns the baud counter and bit shifter.
  - The streamer owns the FSM, row fetch and checksum.

Test Plan:
- Simulation params: CLK_FREQ=1000, BAUD=100 (DIV=10), FRAME_PERIOD=2000, AREA_ROW=4, AREA_COL=16.
- Reset: hold rstn=0 -> uart_tx=1, bitmap_row=0, busy=0, frame_done=0; no start bit for 1999 cycles after release with enable=1.
- Header bits: first tick -> uart_tx low 10 cycles, then data 1,0,1,0,0,1,0,1 (0xA5 LSB first) at 10 cycles each, stop high; next byte decodes 0x5A.
- Payload/checksum: model returns 0 for all rows except row 2 = 32'h8000_0001, data lagging bitmap_row by 1 cycle -> decoded bytes A5 5A 00×8 80 00 00 01 00×4 81; frame_done one pulse; busy low after.
- Snapshot: change bitmap_data for row 1 during its SEND -> transmitted bytes equal the value present in the LATCH cycle.
- Pending: pulse extra ticks mid-frame (FRAME_PERIOD forced short) -> exactly one follow-on frame starts the cycle after DONE; enable=0 on a tick -> no frame.
- Reset mid-frame: assert rstn=0 during row-1 byte 2 -> uart_tx=1 immediately, busy=0; after release the next tick yields a complete, correctly checksummed frame.
